// File: rtl/qspim_ctrl_if.sv
// qspim_ctrl_if: register request port and QSPI pins of the quad-SPI master.
// master = controller side, slave = requester / flash-side view.
interface qspim_ctrl_if;
    logic        reg_wr;
    logic        reg_rd;
    logic [23:0] reg_addr;
    logic [3:0]  reg_be;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_ack;
    logic        busy;
    logic        sclk;
    logic        ssn;
    logic [3:0]  sdout;
    logic        sdout_oen;
    logic [3:0]  sdin;

    modport master (
        input  reg_wr, reg_rd, reg_addr, reg_be, reg_wdata, sdin,
        output reg_rdata, reg_ack, busy, sclk, ssn, sdout, sdout_oen
    );

    modport slave (
        output reg_wr, reg_rd, reg_addr, reg_be, reg_wdata, sdin,
        input  reg_rdata, reg_ack, busy, sclk, ssn, sdout, sdout_oen
    );
endinterface

// File: rtl/qspim_ctrl.sv
// qspim_ctrl: quad-SPI master, one register request -> one 4-lane frame.
// Optional QSPIM_LATE_SAMPLE_EN: read data sampled on falling sclk edges.
module qspim_ctrl #(
    parameter int CLK_DIV   = 1,
    parameter int DUMMY_CYC = 8,
    parameter int CS_GAP    = 2
) (
    input  logic         sys_clk,
    input  logic         rst_n,
    qspim_ctrl_if.master bus
);

    localparam logic [7:0] DIV   = 8'(CLK_DIV);
    localparam logic [4:0] DLAST = 5'(DUMMY_CYC - 1);
    localparam logic [3:0] GLAST = 4'(CS_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WDATA,
        S_DUMMY, S_RDATA, S_DONE, S_GAP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_div;
    logic        r_sclk;
    logic        r_ssn;
    logic        r_oen;
    logic        r_ack;
    logic        r_rd;
    logic [3:0]  r_sdout;
    logic [59:0] r_tx;
    logic [31:0] r_shift;
    logic [31:0] r_rdata;
    logic [4:0]  r_cnt;
    logic [3:0]  r_gap;

    logic w_req;
    logic w_tick;
    logic w_active;
    logic w_dphase;
    logic w_rise;
    logic w_fall;
    logic w_end;
    logic w_last;

    assign w_req    = bus.reg_wr | bus.reg_rd;
    assign w_tick   = (r_div == DIV);
    assign w_active = (r_state == S_CMD) || (r_state == S_ADDR) ||
                      (r_state == S_WDATA) || (r_state == S_DUMMY) ||
                      (r_state == S_RDATA);
    assign w_dphase = (r_state == S_DUMMY) || (r_state == S_RDATA);
    assign w_rise   = w_tick & ~r_sclk & w_active;
    assign w_fall   = w_tick & r_sclk;
    assign w_end    = w_tick & ~r_sclk & (r_state == S_DONE);

    // Last rising edge of the current phase
    always_comb begin
        w_last = 1'b0;
        case (r_state)
            S_CMD:   w_last = (r_cnt == 5'd1);
            S_ADDR:  w_last = (r_cnt == 5'd5);
            S_WDATA: w_last = (r_cnt == 5'd7);
            S_RDATA: w_last = (r_cnt == 5'd7);
            S_DUMMY: w_last = (r_cnt == DLAST);
            default: w_last = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_req) w_next = S_CMD;
            S_CMD:   if (w_rise && w_last) w_next = S_ADDR;
            S_ADDR:  if (w_rise && w_last) w_next = r_rd ? S_DUMMY : S_WDATA;
            S_WDATA: if (w_rise && w_last) w_next = S_DONE;
            S_DUMMY: if (w_rise && w_last) w_next = S_RDATA;
            S_RDATA: if (w_rise && w_last) w_next = S_DONE;
            S_DONE:  if (w_end) w_next = S_GAP;
            S_GAP:   if (r_gap == GLAST) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // sclk half-period divider, parked at zero outside a frame
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)                                  r_div <= '0;
        else if (r_state == S_IDLE || r_state == S_GAP) r_div <= '0;
        else if (w_tick)                             r_div <= '0;
        else                                         r_div <= r_div + 8'd1;
    end

    // Frame datapath: pins, nibble shifter, read capture, ack
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk  <= 1'b0;
            r_ssn   <= 1'b1;
            r_oen   <= 1'b1;
            r_ack   <= 1'b0;
            r_rd    <= 1'b0;
            r_sdout <= '0;
            r_tx    <= '0;
            r_shift <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_gap   <= '0;
        end else begin
            r_ack <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_req) begin
                    // write wins when both are held
                    r_rd    <= ~bus.reg_wr;
                    r_sdout <= bus.reg_wr ? 4'h2 : 4'hB;
                    r_tx    <= {bus.reg_be, bus.reg_addr, bus.reg_wdata};
                    r_ssn   <= 1'b0;
                    r_oen   <= 1'b0;
                    r_sclk  <= 1'b0;
                    r_cnt   <= '0;
                end
            end else if (w_rise) begin
                r_sclk <= 1'b1;
                r_cnt  <= w_last ? 5'd0 : r_cnt + 5'd1;
`ifndef QSPIM_LATE_SAMPLE_EN
                if (r_state == S_RDATA)
                    r_shift <= {r_shift[27:0], bus.sdin};
`endif
            end else if (w_fall) begin
                r_sclk <= 1'b0;
                if (w_dphase) begin
                    r_oen   <= 1'b1;
                    r_sdout <= 4'h0;
                end else if (r_state != S_DONE) begin
                    r_sdout <= r_tx[59:56];
                    r_tx    <= {r_tx[55:0], 4'h0};
                end
`ifdef QSPIM_LATE_SAMPLE_EN
                // nine shifts per read; the first (a dummy nibble) drops out
                if (r_state == S_RDATA || (r_state == S_DONE && r_rd))
                    r_shift <= {r_shift[27:0], bus.sdin};
`endif
            end else if (w_end) begin
                r_ssn   <= 1'b1;
                r_oen   <= 1'b1;
                r_sdout <= 4'h0;
                r_ack   <= 1'b1;
                r_gap   <= '0;
                if (r_rd) r_rdata <= r_shift;
            end else if (r_state == S_GAP) begin
                r_gap <= r_gap + 4'd1;
            end
        end
    end

    assign bus.sclk      = r_sclk;
    assign bus.ssn       = r_ssn;
    assign bus.sdout     = r_sdout;
    assign bus.sdout_oen = r_oen;
    assign bus.reg_ack   = r_ack;
    assign bus.reg_rdata = r_rdata;
    assign bus.busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_qspim_ctrl.sv
// tb_qspim_ctrl: two masters (CLK_DIV 1 and 0) against a frame-level model.
// Define QSPIM_LATE_SAMPLE_EN to run the delayed-slave variant.
module tb_qspim_ctrl;

    localparam int D = 8;
    localparam int G = 2;

    typedef struct {
        bit          rd;
        logic [3:0]  be;
        logic [23:0] addr;
        logic [31:0] wd;
        logic [31:0] sd;
    } txn_t;

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    logic        wr_v   [2];
    logic        rd_v   [2];
    logic [23:0] addr_v [2];
    logic [3:0]  be_v   [2];
    logic [31:0] wd_v   [2];
    logic [3:0]  sdin_v [2];

    logic        w_sclk  [2];
    logic        w_ssn   [2];
    logic [3:0]  w_sdout [2];
    logic        w_oen   [2];
    logic        w_ack   [2];
    logic        w_busy  [2];
    logic [31:0] w_rdata [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        qspim_ctrl_if bus_if ();
        assign bus_if.reg_wr    = wr_v[g];
        assign bus_if.reg_rd    = rd_v[g];
        assign bus_if.reg_addr  = addr_v[g];
        assign bus_if.reg_be    = be_v[g];
        assign bus_if.reg_wdata = wd_v[g];
        assign bus_if.sdin      = sdin_v[g];
        assign w_sclk[g]  = bus_if.sclk;
        assign w_ssn[g]   = bus_if.ssn;
        assign w_sdout[g] = bus_if.sdout;
        assign w_oen[g]   = bus_if.sdout_oen;
        assign w_ack[g]   = bus_if.reg_ack;
        assign w_busy[g]  = bus_if.busy;
        assign w_rdata[g] = bus_if.reg_rdata;
        qspim_ctrl #(
            .CLK_DIV   ((g == 0) ? 1 : 0),
            .DUMMY_CYC (D),
            .CS_GAP    (G)
        ) u_dut (
            .sys_clk (sys_clk),
            .rst_n   (rst_n),
            .bus     (bus_if)
        );
    end

    // expected transactions, pushed by the requester, popped per frame
    txn_t exp_tab [2][16];
    int   n_push  [2];
    int   n_pop   [2];

    txn_t        cur        [2];
    bit          in_frame   [2];
    bit          in_gap     [2];
    bit          seen       [2];
    logic        p_sclk     [2];
    logic        p_ssn      [2];
    logic [3:0]  p_sdout    [2];
    int          since      [2];
    int          rises      [2];
    int          hi_run     [2];
    int          gap_cnt    [2];
    int          last_rises [2];
    logic [63:0] cap        [2];
    logic [63:0] last_cap   [2];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // whole frame as the slave should see it, nibble 0 first
    function automatic logic [63:0] frame(input txn_t t);
        return {(t.rd ? 4'hB : 4'h2), t.be, t.addr, t.wd};
    endfunction

    function automatic logic [3:0] nib64(input logic [63:0] v, input int i);
        return 4'(v >> (60 - 4 * i));
    endfunction

    function automatic logic [3:0] nib32(input logic [31:0] v, input int i);
        return 4'(v >> (28 - 4 * i));
    endfunction

    // Frame monitor, slave model and compare, both DUTs
    always @(negedge sys_clk) begin : mon
        int k;
        int dv;
        for (int g = 0; g < 2; g++) begin
            dv = (g == 0) ? 1 : 0;
            if (!rst_n) begin
                in_frame[g] = 0;
                in_gap[g]   = 0;
                seen[g]     = 0;
                p_sclk[g]   = 1'b0;
                p_ssn[g]    = 1'b1;
                p_sdout[g]  = 4'h0;
                sdin_v[g]   = 4'h0;
                hi_run[g]   = 0;
                since[g]    = 0;
            end else begin
                if (p_ssn[g] && !w_ssn[g]) begin
                    if (seen[g])
                        chk($sformatf("d%0d_ss_high_min", g),
                            64'(hi_run[g] >= G), 1);
                    if (n_pop[g] < n_push[g]) begin
                        cur[g] = exp_tab[g][n_pop[g]];
                        n_pop[g]++;
                        in_frame[g] = 1;
                    end else begin
                        chk($sformatf("d%0d_unexpected_frame", g), 1, 0);
                    end
                    rises[g] = 0;
                    cap[g]   = '0;
                    since[g] = 0;
                end else begin
                    since[g]++;
                end
                if (in_frame[g] && w_sclk[g] != p_sclk[g]) begin
                    chk($sformatf("d%0d_half_period", g), since[g], dv + 1);
                    since[g] = 0;
                    k = rises[g];
                    if (w_sclk[g]) begin
                        chk($sformatf("d%0d_busy_in_frame", g), w_busy[g], 1);
                        if (!cur[g].rd || k < 8) begin
                            chk($sformatf("d%0d_nib%0d", g, k), w_sdout[g],
                                nib64(frame(cur[g]), k));
                            chk($sformatf("d%0d_oen_drive%0d", g, k),
                                w_oen[g], 0);
                            cap[g] = {cap[g][59:0], w_sdout[g]};
                        end else begin
                            chk($sformatf("d%0d_oen_release%0d", g, k),
                                w_oen[g], 1);
                        end
`ifdef QSPIM_LATE_SAMPLE_EN
                        if (cur[g].rd && k >= 8 + D && k < 16 + D)
                            sdin_v[g] = nib32(cur[g].sd, k - 8 - D);
`endif
                        rises[g]++;
                    end else begin
`ifndef QSPIM_LATE_SAMPLE_EN
                        if (cur[g].rd && k >= 8 + D && k < 16 + D)
                            sdin_v[g] = nib32(cur[g].sd, k - 8 - D);
`endif
                    end
                end
                if (!w_ssn[g] && w_sdout[g] != p_sdout[g])
                    chk($sformatf("d%0d_sdout_while_sclk_low", g),
                        w_sclk[g], 0);
                if (w_ack[g]) begin
                    chk($sformatf("d%0d_ack_in_frame", g), in_frame[g], 1);
                    chk($sformatf("d%0d_ack_ssn", g), w_ssn[g], 1);
                    chk($sformatf("d%0d_ss_tail", g), since[g], dv + 1);
                    chk($sformatf("d%0d_rise_cnt", g), rises[g],
                        cur[g].rd ? 16 + D : 16);
                    if (cur[g].rd)
                        chk($sformatf("d%0d_rdata", g), w_rdata[g], cur[g].sd);
                    last_rises[g] = rises[g];
                    last_cap[g]   = cap[g];
                    in_frame[g]   = 0;
                    in_gap[g]     = 1;
                    gap_cnt[g]    = 0;
                    seen[g]       = 1;
                end else if (!p_ssn[g] && w_ssn[g]) begin
                    chk($sformatf("d%0d_frame_without_ack", g), 0, 1);
                    in_frame[g] = 0;
                end
                if (in_gap[g]) begin
                    if (w_busy[g] && w_ssn[g]) begin
                        gap_cnt[g]++;
                    end else begin
                        chk($sformatf("d%0d_gap_len", g), gap_cnt[g], G);
                        in_gap[g] = 0;
                    end
                end
                hi_run[g]  = w_ssn[g] ? hi_run[g] + 1 : 0;
                p_sclk[g]  = w_sclk[g];
                p_ssn[g]   = w_ssn[g];
                p_sdout[g] = w_sdout[g];
            end
        end
    end

    task automatic push(input int g, input bit rd, input logic [3:0] be,
                        input logic [23:0] a, input logic [31:0] wd,
                        input logic [31:0] sd);
        txn_t t;
        t.rd = rd; t.be = be; t.addr = a; t.wd = wd; t.sd = sd;
        exp_tab[g][n_push[g]] = t;
        n_push[g]++;
    endtask

    task automatic launch(input int g, input bit w, input bit r,
                          input logic [3:0] be, input logic [23:0] a,
                          input logic [31:0] wd, input logic [31:0] sd);
        int got;
        int need;
        @(negedge sys_clk);
        #1;
        need = 0;
        if (w) begin push(g, 0, be, a, wd, sd); need++; end
        if (r) begin push(g, 1, be, a, wd, sd); need++; end
        be_v[g] = be; addr_v[g] = a; wd_v[g] = wd;
        wr_v[g] = w;  rd_v[g] = r;
        got = 0;
        for (int c = 0; c < 3000 && got < need; c++) begin
            @(negedge sys_clk);
            #1;
            if (w_ack[g]) begin
                got++;
                if (wr_v[g]) wr_v[g] = 1'b0;
                else         rd_v[g] = 1'b0;
            end
        end
        wr_v[g] = 1'b0;
        rd_v[g] = 1'b0;
        chk($sformatf("d%0d_ack_count", g), got, need);
    endtask

    initial begin : stim
        bit hit;
        for (int g = 0; g < 2; g++) begin
            wr_v[g] = 0; rd_v[g] = 0; addr_v[g] = '0;
            be_v[g] = '0; wd_v[g] = '0;
            n_push[g] = 0; n_pop[g] = 0;
        end
        repeat (3) @(negedge sys_clk);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("d%0d_rst_ssn", g),   w_ssn[g],   1);
            chk($sformatf("d%0d_rst_sclk", g),  w_sclk[g],  0);
            chk($sformatf("d%0d_rst_sdout", g), w_sdout[g], 0);
            chk($sformatf("d%0d_rst_oen", g),   w_oen[g],   1);
            chk($sformatf("d%0d_rst_ack", g),   w_ack[g],   0);
            chk($sformatf("d%0d_rst_rdata", g), w_rdata[g], 0);
            chk($sformatf("d%0d_rst_busy", g),  w_busy[g],  0);
        end
        rst_n = 1'b1;

        // write frame, CLK_DIV=1
        launch(0, 1, 0, 4'hF, 24'h001234, 32'hDEADBEEF, 32'h0);
        chk("wr_frame_literal", last_cap[0], 64'h2F001234DEADBEEF);
        chk("wr_rises_literal", last_rises[0], 16);

        // read frame
        launch(0, 0, 1, 4'h3, 24'hABCDEF, 32'h0, 32'h12345678);
        chk("rd_hdr_literal", last_cap[0][31:0], 32'hB3ABCDEF);
        chk("rd_rises_literal", last_rises[0], 24);
        chk("rd_data_literal", w_rdata[0], 32'h12345678);

        // both requests held: write, then read
        launch(0, 1, 1, 4'hC, 24'h55AA01, 32'hCAFEF00D, 32'h89ABCDEF);
        chk("both_rdata_literal", w_rdata[0], 32'h89ABCDEF);

        // reset at the 5th sclk rise of a write
        @(negedge sys_clk);
        #1;
        push(0, 0, 4'hF, 24'h0F0F0F, 32'h11112222, 32'h0);
        be_v[0] = 4'hF; addr_v[0] = 24'h0F0F0F; wd_v[0] = 32'h11112222;
        wr_v[0] = 1'b1;
        hit = 0;
        for (int c = 0; c < 500 && !hit; c++) begin
            @(negedge sys_clk);
            #1;
            if (rises[0] == 5) hit = 1;
        end
        chk("abort_reached_5th_sclk", hit, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_ssn",  w_ssn[0],  1);
        chk("abort_sclk", w_sclk[0], 0);
        chk("abort_oen",  w_oen[0],  1);
        chk("abort_ack",  w_ack[0],  0);
        chk("abort_busy", w_busy[0], 0);
        wr_v[0] = 1'b0;
        repeat (3) @(negedge sys_clk);
        #1;
        rst_n = 1'b1;
        launch(0, 1, 0, 4'h1, 24'hFEDCBA, 32'h01234567, 32'h0);
        chk("post_abort_frame", last_cap[0], 64'h21FEDCBA01234567);

        // CLK_DIV=0, three back-to-back reads
        launch(1, 0, 1, 4'hF, 24'h000100, 32'h0, 32'hA5A55A5A);
        chk("d1_rd0_literal", w_rdata[1], 32'hA5A55A5A);
        launch(1, 0, 1, 4'h1, 24'h800001, 32'h0, 32'h13579BDF);
        chk("d1_rd1_literal", w_rdata[1], 32'h13579BDF);
        launch(1, 0, 1, 4'h8, 24'h7FFFFE, 32'h0, 32'hF0E1D2C3);
        chk("d1_rd2_literal", w_rdata[1], 32'hF0E1D2C3);
        chk("d1_rises_literal", last_rises[1], 24);

        repeat (6) @(negedge sys_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
